// File: rtl/imem_dmem_port_scheduler_pkg.sv
// rtl/imem_dmem_port_scheduler_pkg.sv - shared types and constants for the memory port scheduler
package mem_arb_pkg;

  // Owner of the read-response slot one cycle after issue
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_t;

  localparam int MEM_RD_LATENCY       = 1;
  localparam int DEFAULT_MAX_DATA_RUN = 4;

endpackage

// File: rtl/imem_dmem_port_scheduler_if.sv
// rtl/imem_dmem_port_scheduler_if.sv - fetch, LSU and memory-macro signals of the port scheduler
interface imem_dmem_port_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_flush;

  logic              lsu_req;
  logic              lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [3:0]        lsu_be;
  logic              lsu_gnt;
  logic              lsu_rvalid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              stall_pc;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, if_flush,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  stall_pc,
    input  mem_addr, mem_we, mem_wdata, mem_be
  );

  modport slave (
    input  if_req, if_addr, if_flush,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output stall_pc,
    output mem_addr, mem_we, mem_wdata, mem_be
  );

endinterface

// File: rtl/imem_dmem_port_scheduler_fair_ctr.sv
// rtl/imem_dmem_port_scheduler_fair_ctr.sv - saturating data-run counter and force-fetch decision
module mem_arb_fair_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = DEFAULT_MAX_DATA_RUN
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic lsu_gnt_i,
  output logic force_fetch_o
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  logic [3:0] run_q, run_d;

  // Only data grants that actually starve a waiting fetch count toward the run
  always_comb begin
    run_d = run_q;
    if (!if_req_i || if_gnt_i) begin
      run_d = '0;
    end else if (lsu_gnt_i && (run_q != RUN_MAX)) begin
      run_d = run_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  assign force_fetch_o = (run_q == RUN_MAX);

endmodule

// File: rtl/imem_dmem_port_scheduler.sv
// rtl/imem_dmem_port_scheduler.sv - arbitrates the shared single-port memory between fetch and LSU
module imem_dmem_port_scheduler
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = DEFAULT_MAX_DATA_RUN
) (
  input logic                         clk,
  input logic                         rst,
  imem_dmem_port_scheduler_if.slave   bus
);

  owner_t owner_q, owner_d;
  logic   flush_pend_q, flush_pend_d;
  logic   force_fetch;
  logic   gnt_if, gnt_lsu;

  mem_arb_fair_ctr #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_fair_ctr (
    .clk           (clk),
    .rst           (rst),
    .if_req_i      (bus.if_req),
    .if_gnt_i      (gnt_if),
    .lsu_gnt_i     (gnt_lsu),
    .force_fetch_o (force_fetch)
  );

  // LSU wins unless a pending fetch has already waited out the full data run
  always_comb begin
    gnt_lsu = !rst && bus.lsu_req && (!bus.if_req || !force_fetch);
    gnt_if  = !rst && bus.if_req && !gnt_lsu;
  end

  always_comb begin
    bus.mem_addr  = ADDR_W'(0);
    bus.mem_wdata = DATA_W'(0);
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    if (gnt_if) begin
      bus.mem_addr = bus.if_addr;
    end else if (gnt_lsu) begin
      bus.mem_addr  = bus.lsu_addr;
      bus.mem_wdata = bus.lsu_wdata;
      bus.mem_we    = bus.lsu_we;
      bus.mem_be    = bus.lsu_we ? bus.lsu_be : 4'b0000;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_if) begin
      owner_d = OWN_IF;
    end else if (gnt_lsu && !bus.lsu_we) begin
      owner_d = OWN_LD;
    end
    flush_pend_d = gnt_if && bus.if_flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      flush_pend_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // A flush either at issue or in the response cycle kills the fetch response
  always_comb begin
    bus.if_rvalid  = !rst && (owner_q == OWN_IF) && !bus.if_flush && !flush_pend_q;
    bus.lsu_rvalid = !rst && (owner_q == OWN_LD);
    bus.if_rdata   = bus.if_rvalid  ? bus.mem_rdata : DATA_W'(0);
    bus.lsu_rdata  = bus.lsu_rvalid ? bus.mem_rdata : DATA_W'(0);
  end

  assign bus.if_gnt   = gnt_if;
  assign bus.lsu_gnt  = gnt_lsu;
  assign bus.stall_pc = !rst && bus.if_req && !gnt_if;

endmodule

// File: tb/tb_imem_dmem_port_scheduler.sv
// tb/tb_imem_dmem_port_scheduler.sv - self-checking bench for imem_dmem_port_scheduler
module tb_imem_dmem_port_scheduler;

  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  imem_dmem_port_scheduler_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  imem_dmem_port_scheduler #(.ADDR_W(10), .DATA_W(32), .MAX_DATA_RUN(MAXR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: response slot from last cycle and length of the current data run
  int          m_run  = 0;
  int          m_resp = 0;
  bit          m_pend = 0;

  always @(negedge clk) begin
    bit gl, gf, ev_if, ev_ld;
    if (rst) begin
      gl = 0; gf = 0; ev_if = 0; ev_ld = 0;
    end else begin
      gl = bus.lsu_req && (!bus.if_req || m_run < MAXR);
      gf = bus.if_req && !gl;
      ev_if = (m_resp == 1) && !bus.if_flush && !m_pend;
      ev_ld = (m_resp == 2);
    end
    chk("m_if_gnt",   bus.if_gnt, gf);
    chk("m_lsu_gnt",  bus.lsu_gnt, gl);
    chk("m_stall_pc", bus.stall_pc, !rst && bus.if_req && !gf);
    chk("m_mem_addr", bus.mem_addr, gf ? bus.if_addr : gl ? bus.lsu_addr : 10'd0);
    chk("m_mem_we",   bus.mem_we, gl && bus.lsu_we);
    chk("m_mem_be",   bus.mem_be, (gl && bus.lsu_we) ? bus.lsu_be : 4'd0);
    chk("m_mem_wdata", bus.mem_wdata, gl ? bus.lsu_wdata : 32'd0);
    chk("m_if_rvalid",  bus.if_rvalid, ev_if);
    chk("m_if_rdata",   bus.if_rdata, ev_if ? bus.mem_rdata : 32'd0);
    chk("m_lsu_rvalid", bus.lsu_rvalid, ev_ld);
    chk("m_lsu_rdata",  bus.lsu_rdata, ev_ld ? bus.mem_rdata : 32'd0);
    if (rst) begin
      m_run = 0; m_resp = 0; m_pend = 0;
    end else begin
      if (gf || !bus.if_req) m_run = 0;
      else if (gl) m_run = (m_run + 1 > MAXR) ? MAXR : m_run + 1;
      m_resp = gf ? 1 : (gl && !bus.lsu_we) ? 2 : 0;
      m_pend = gf && bus.if_flush;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = 0; bus.lsu_wdata = 0; bus.lsu_be = 0;
    bus.mem_rdata = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    next_cycle();
    @(negedge clk);
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_lsu_rvalid", bus.lsu_rvalid, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    next_cycle();
    rst = 0;

    // Fetch only
    for (int a = 0; a < 4; a++) begin
      bus.if_req = (a < 3);
      bus.if_addr = 10'(a);
      bus.mem_rdata = (a == 0) ? 32'd0 : 32'hA0 + 32'(a - 1);
      @(negedge clk);
      if (a < 3) begin
        chk("fo_if_gnt", bus.if_gnt, 1);
        chk("fo_stall", bus.stall_pc, 0);
      end
      if (a > 0) begin
        chk("fo_if_rvalid", bus.if_rvalid, 1);
        chk("fo_if_rdata", bus.if_rdata, 32'hA0 + 32'(a - 1));
      end
      next_cycle();
    end
    idle();

    // Store collision
    bus.if_req = 1; bus.if_addr = 10'h010;
    bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_addr = 10'h3FF;
    bus.lsu_wdata = 32'hDEADBEEF; bus.lsu_be = 4'hF;
    @(negedge clk);
    chk("sc_lsu_gnt", bus.lsu_gnt, 1);
    chk("sc_mem_we", bus.mem_we, 1);
    chk("sc_mem_addr", bus.mem_addr, 10'h3FF);
    chk("sc_stall", bus.stall_pc, 1);
    next_cycle();
    bus.lsu_req = 0; bus.lsu_we = 0;
    @(negedge clk);
    chk("sc_if_gnt", bus.if_gnt, 1);
    chk("sc_no_lsu_rvalid", bus.lsu_rvalid, 0);
    chk("sc_no_if_rvalid", bus.if_rvalid, 0);
    next_cycle();
    idle();

    // Load return
    bus.lsu_req = 1; bus.lsu_addr = 10'h020;
    next_cycle();
    bus.lsu_req = 0; bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("ld_lsu_rvalid", bus.lsu_rvalid, 1);
    chk("ld_lsu_rdata", bus.lsu_rdata, 32'h12345678);
    chk("ld_if_rvalid", bus.if_rvalid, 0);
    chk("ld_if_rdata", bus.if_rdata, 0);
    next_cycle();
    idle();
    next_cycle();

    // Fairness: L L L L F L L L L F
    bus.if_req = 1; bus.if_addr = 10'h100; bus.lsu_req = 1; bus.lsu_addr = 10'h200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fair_if_gnt", bus.if_gnt, (i % 5) == 4);
      chk("fair_stall", bus.stall_pc, (i % 5) != 4);
      next_cycle();
    end
    idle();
    next_cycle();

    // Flush in response cycle, back-to-back load
    bus.if_req = 1; bus.if_addr = 10'h040;
    next_cycle();
    bus.if_req = 0; bus.if_flush = 1; bus.lsu_req = 1; bus.lsu_addr = 10'h050;
    bus.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("fl_if_rvalid", bus.if_rvalid, 0);
    chk("fl_ld_gnt", bus.lsu_gnt, 1);
    next_cycle();
    bus.if_flush = 1; bus.lsu_req = 0; bus.mem_rdata = 32'h55;
    @(negedge clk);
    chk("fl_lsu_rvalid", bus.lsu_rvalid, 1);
    chk("fl_lsu_rdata", bus.lsu_rdata, 32'h55);
    next_cycle();
    idle();

    // Reset mid-flight
    bus.lsu_req = 1; bus.lsu_addr = 10'h077;
    @(negedge clk);
    chk("rm_lsu_gnt", bus.lsu_gnt, 1);
    next_cycle();
    bus.lsu_req = 0; rst = 1; bus.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rm_rvalid_in_rst", bus.lsu_rvalid, 0);
    chk("rm_rdata_in_rst", bus.lsu_rdata, 0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("rm_rvalid_after", bus.lsu_rvalid, 0);
    next_cycle();

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.if_req = $urandom_range(0, 3) != 0;
      bus.if_addr = 10'($urandom);
      bus.if_flush = $urandom_range(0, 5) == 0;
      bus.lsu_req = $urandom_range(0, 2) != 0;
      bus.lsu_we = $urandom_range(0, 2) == 0;
      bus.lsu_addr = 10'($urandom);
      bus.lsu_wdata = $urandom;
      bus.lsu_be = 4'($urandom);
      bus.mem_rdata = $urandom;
      next_cycle();
    end
    rst = 0;
    idle();
    next_cycle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
